// File: rtl/if_align.sv
`default_nettype none
// ============================================================================
//  Module      : if_align
//  Description : Halfword realignment buffer between fetch and decode.
//                Splits aligned 32-bit fetch words into a stream of 16-bit
//                compressed and 32-bit instructions at any halfword offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_align (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_word,
    output logic        fetch_stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_c
);

    localparam int c_DEPTH = 4;

    // Halfword queue, entry 0 is the head
    logic [15:0] r_hw [c_DEPTH];
    logic [31:0] r_pc [c_DEPTH];
    logic [2:0]  r_count;
    logic        r_skip_low;

    logic        w_loadable;
    logic        w_head_c;
    logic [1:0]  w_pop_n;
    logic [2:0]  w_after_pop;
    logic        w_consume;
    logic [1:0]  w_push_n;
    logic [15:0] w_push_hw [2];
    logic [31:0] w_push_pc [2];
    logic [15:0] w_hw_nxt [c_DEPTH];
    logic [31:0] w_pc_nxt [c_DEPTH];
    logic [2:0]  w_count_nxt;
    logic        w_unused;

    // Only bit 1 of the redirect target and the word address of fetch matter
    assign w_unused = ^{fetch_pc[1:0], flush_pc[31:2], flush_pc[0]};

    assign w_loadable = !instr_valid || !id_stall;
    assign w_head_c   = (r_hw[0][1:0] != 2'b11);

    // Pop decision: one halfword for compressed, two for a full instruction
    always_comb begin
        w_pop_n = 2'd0;
        if (w_loadable) begin
            if (w_head_c && (r_count >= 3'd1)) begin
                w_pop_n = 2'd1;
            end else if (!w_head_c && (r_count >= 3'd2)) begin
                w_pop_n = 2'd2;
            end
        end
    end

    // Stall fetch when the remaining entries could not absorb a full word
    assign w_after_pop = r_count - {1'b0, w_pop_n};
    assign fetch_stall = (w_after_pop > 3'd2);
    assign w_consume   = fetch_valid && !fetch_stall && !flush;

    // Halfwords offered by the current word; after an odd redirect only the
    // high halfword belongs to the target path
    always_comb begin
        w_push_hw[0] = fetch_word[15:0];
        w_push_pc[0] = {fetch_pc[31:2], 2'b00};
        w_push_hw[1] = fetch_word[31:16];
        w_push_pc[1] = {fetch_pc[31:2], 2'b10};
        w_push_n     = 2'd0;
        if (r_skip_low) begin
            w_push_hw[0] = fetch_word[31:16];
            w_push_pc[0] = {fetch_pc[31:2], 2'b10};
        end
        if (w_consume) begin
            w_push_n = r_skip_low ? 2'd1 : 2'd2;
        end
    end

    assign w_count_nxt = w_after_pop + {1'b0, w_push_n};

    // Next queue contents: shift out popped entries, append pushed halfwords
    always_comb begin
        logic [2:0] w_k;
        logic [1:0] w_src;
        w_k   = '0;
        w_src = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_hw_nxt[i] = r_hw[i];
            w_pc_nxt[i] = r_pc[i];
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            w_k   = 3'(i) - w_after_pop;
            w_src = 2'(i) + w_pop_n;
            if (3'(i) < w_after_pop) begin
                w_hw_nxt[i] = r_hw[w_src];
                w_pc_nxt[i] = r_pc[w_src];
            end else if (3'(i) < w_count_nxt) begin
                w_hw_nxt[i] = w_push_hw[w_k[0]];
                w_pc_nxt[i] = w_push_pc[w_k[0]];
            end
        end
    end

    // Queue state; a redirect empties it and arms the partial-word skip
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 3'd0;
            r_skip_low <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_hw[i] <= '0;
                r_pc[i] <= '0;
            end
        end else if (flush) begin
            r_count    <= 3'd0;
            r_skip_low <= flush_pc[1];
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_hw[i] <= w_hw_nxt[i];
                r_pc[i] <= w_pc_nxt[i];
            end
            if (w_consume) begin
                r_skip_low <= 1'b0;
            end
        end
    end

    // Output register toward decode; holds while decode is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_c     <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (w_loadable) begin
            if (w_pop_n == 2'd1) begin
                instr_valid <= 1'b1;
                instr       <= {16'b0, r_hw[0]};
                instr_pc    <= r_pc[0];
                instr_c     <= 1'b1;
            end else if (w_pop_n == 2'd2) begin
                instr_valid <= 1'b1;
                instr       <= {r_hw[1], r_hw[0]};
                instr_pc    <= r_pc[0];
                instr_c     <= 1'b0;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_align
//  Description : Self-checking bench for if_align: directed vector table plus
//                streamed compressed sequences with decode back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_word;
    logic        fetch_stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_c;

    int n_cmp  = 0;
    int n_fail = 0;

    if_align dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_word  (fetch_word),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .id_stall    (id_stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_c     (instr_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          fv;
        logic [31:0] fpc;
        logic [31:0] fword;
        bit          fl;
        logic [31:0] flpc;
        bit          ids;
        bit          cs;     // check fetch_stall before the edge
        bit          es;
        bit          cd;     // check instr/instr_pc/instr_c after the edge
        bit          ev;
        logic [31:0] ei;
        logic [31:0] epc;
        bit          ec;
    } vec_t;

    vec_t vt[25];

    function automatic vec_t mk(bit rst, bit fv, logic [31:0] fpc, logic [31:0] fword,
                                bit fl, logic [31:0] flpc, bit ids, bit cs, bit es,
                                bit cd, bit ev, logic [31:0] ei, logic [31:0] epc, bit ec);
        vec_t v;
        v.rst = rst; v.fv = fv; v.fpc = fpc; v.fword = fword; v.fl = fl; v.flpc = flpc;
        v.ids = ids; v.cs = cs; v.es = es; v.cd = cd; v.ev = ev; v.ei = ei; v.epc = epc;
        v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fetch memory for streamed runs: every halfword compressed and unique
    function automatic logic [15:0] gen_hw(input logic [31:0] h);
        return {h[14:1], 2'b01};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h4505_4501;
        if (a == 32'h104) return 32'h4509_450D;
        return {gen_hw(a + 32'd2), gen_hw(a)};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] h);
        logic [31:0] w;
        w = mem_word({h[31:2], 2'b00});
        return h[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic run_stream(input bit do_stall, input string tag);
        logic [31:0] f_pc;
        logic [31:0] eq_i[$];
        logic [31:0] eq_pc[$];
        logic [64:0] snap;
        int          left;
        bit          started;
        bit          seen_stall;
        bit          st;
        logic [31:0] ei;
        logic [31:0] epc;

        reset = 1'b1; fetch_valid = 1'b0; flush = 1'b0; id_stall = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (logic [31:0] h = 32'h100; h < 32'h120; h += 32'd2) begin
            eq_i.push_back({16'b0, hw_at(h)});
            eq_pc.push_back(h);
        end
        f_pc = 32'h100; left = 0; started = 1'b0; seen_stall = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 100 && eq_i.size() > 0; cyc++) begin
            if (do_stall && !started && instr_valid) begin
                started = 1'b1;
                left    = 5;
                snap    = {instr_pc, instr, instr_c};
            end
            id_stall    = (left > 0);
            fetch_valid = (f_pc < 32'h120);
            fetch_pc    = f_pc;
            fetch_word  = mem_word(f_pc);
            #1;
            st = fetch_stall;
            if (st) seen_stall = 1'b1;
            if (left > 0 && left < 5)
                check({tag, " frozen"}, {31'b0, instr_valid, instr_pc, instr, instr_c},
                      {31'b0, 1'b1, snap});
            if (left == 1)
                check({tag, " stall_full"}, {95'b0, st}, {95'b0, 1'b1});
            if (instr_valid && !id_stall) begin
                ei  = eq_i.pop_front();
                epc = eq_pc.pop_front();
                check($sformatf("%s out@%h", tag, epc), {31'b0, instr_c, instr_pc, instr},
                      {31'b0, 1'b1, epc, ei});
            end
            @(posedge clk); #1;
            if (fetch_valid && !st) f_pc += 32'd4;
            if (left > 0) left--;
            @(negedge clk);
        end
        check({tag, " remaining"}, 96'(eq_i.size()), 96'd0);
        if (!do_stall)
            check({tag, " stall_seen"}, {95'b0, seen_stall}, {95'b0, 1'b1});
        fetch_valid = 1'b0;
        id_stall    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_word = '0;
        flush = 1'b0; flush_pc = '0; id_stall = 1'b0;

        //          rst fv fpc       fword          fl flpc      ids cs es cd ev ei             epc       ec
        vt[0]  = mk(1, 0, 32'h0,   32'h0,          0, 32'h0,   0, 0, 0, 1, 0, 32'h0,         32'h0,   0);
        vt[1]  = mk(1, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 0, 32'h0,         32'h0,   0);
        vt[2]  = mk(0, 1, 32'h100, 32'h0000_0013,  0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[3]  = mk(0, 1, 32'h104, 32'h0010_0093,  0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_0013, 32'h100, 0);
        vt[4]  = mk(0, 1, 32'h108, 32'h0020_0113,  0, 32'h0,   0, 1, 0, 1, 1, 32'h0010_0093, 32'h104, 0);
        vt[5]  = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0020_0113, 32'h108, 0);
        vt[6]  = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[7]  = mk(0, 1, 32'h200, 32'h0093_4501,  0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[8]  = mk(0, 1, 32'h204, 32'h4505_0010,  0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_4501, 32'h200, 1);
        vt[9]  = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0010_0093, 32'h202, 0);
        vt[10] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_4505, 32'h206, 1);
        vt[11] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[12] = mk(0, 1, 32'h400, 32'hDEAD_BEEF,  1, 32'h302, 0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[13] = mk(0, 1, 32'h302, 32'h4505_1234,  0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[14] = mk(0, 1, 32'h306, 32'h4509_450D,  0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_4505, 32'h302, 1);
        vt[15] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_450D, 32'h304, 1);
        vt[16] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_4509, 32'h306, 1);
        vt[17] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[18] = mk(1, 0, 32'h0,   32'h0,          0, 32'h0,   0, 0, 0, 1, 0, 32'h0,         32'h0,   0);
        vt[19] = mk(0, 1, 32'h100, 32'h4505_4501,  0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[20] = mk(0, 1, 32'h104, 32'h4509_450D,  0, 32'h0,   0, 1, 0, 1, 1, 32'h0000_4501, 32'h100, 1);
        vt[21] = mk(0, 1, 32'h108, 32'h1234_5678,  1, 32'h500, 1, 1, 1, 0, 0, 32'h0,         32'h0,   0);
        vt[22] = mk(0, 1, 32'h500, 32'h0050_0513,  0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);
        vt[23] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 1, 1, 32'h0050_0513, 32'h500, 0);
        vt[24] = mk(0, 0, 32'h0,   32'h0,          0, 32'h0,   0, 1, 0, 0, 0, 32'h0,         32'h0,   0);

        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            reset       = vt[i].rst;
            fetch_valid = vt[i].fv;
            fetch_pc    = vt[i].fpc;
            fetch_word  = vt[i].fword;
            flush       = vt[i].fl;
            flush_pc    = vt[i].flpc;
            id_stall    = vt[i].ids;
            #1;
            if (vt[i].cs)
                check($sformatf("vec%0d fetch_stall", i), {95'b0, fetch_stall}, {95'b0, vt[i].es});
            @(posedge clk); #1;
            check($sformatf("vec%0d instr_valid", i), {95'b0, instr_valid}, {95'b0, vt[i].ev});
            if (vt[i].cd)
                check($sformatf("vec%0d instr/pc/c", i), {31'b0, instr_c, instr_pc, instr},
                      {31'b0, vt[i].ec, vt[i].epc, vt[i].ei});
            @(negedge clk);
        end
        flush = 1'b0; flush_pc = '0; id_stall = 1'b0; fetch_valid = 1'b0;

        run_stream(1'b0, "cstream");
        run_stream(1'b1, "idstall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
